i2c_codec_responder: RTL
========================

Name: i2c_codec_responder

Overview:
I2C target that emulates the audio codec's write-only control port, the far end of the audio configuration I2C master. It accepts 3-byte codec writes: device address, then {reg_addr[6:0], data[8]}, then data[7:0]. It returns ACKs by driving SDA low through an open-drain enable and presents each completed register write as a one-cycle strobe. Used as a codec stand-in on the bench and as a register-shadow front end in the fabric.

Parameters:
DEVICE_ADDR, 7'h1A, 7-bit target address to acknowledge
FILTER_LEN, 3, consecutive clk cycles a synchronised SCL/SDA level must hold before it is accepted (1..15)

Ports:
clk  input  1  system clock, at least 20x SCL frequency
reset  input  1  asynchronous, active-high reset
scl_in  input  1  I2C SCL pin level, asynchronous
sda_in  input  1  I2C SDA pin level, asynchronous
sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release
wr_valid  output  1  one-cycle strobe: register write completed
wr_addr  output  7  codec register address, valid while wr_valid=1, held until the next write
wr_data  output  9  codec register data, valid while wr_valid=1, held until the next write
busy  output  1  1 from an accepted START until the following STOP
err_count  output  8  saturating count of rejected or aborted transactions

Behaviour:
- Reset (async assert, sync release): sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, err_count=0, FSM=IDLE, bit counter=0, filters preset to 1 (bus idle).
- Input path: 2-FF synchroniser per line, then glitch filter. The filtered level changes only after FILTER_LEN consecutive identical samples. Edges are detected on the filtered signals, one cycle after the filter output changes.
- START: filtered SDA falls while filtered SCL=1. STOP: filtered SDA rises while filtered SCL=1. Both are recognised in every state and take priority over data sampling in the same cycle.
- Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes only on the SCL falling edge.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- IDLE: START -> ADDR, busy=1, bit counter=0.
- ADDR: shift 8 bits.
  - After the 8th rising edge, if addr==DEVICE_ADDR and R/W=0 -> ACK_A.
  - Address matches but R/W=1 (reads unsupported): err_count+1, -> IGNORE with no ACK.
  - Address mismatch -> IGNORE with no ACK and no error count.
- ACK_x: on the SCL falling edge that enters ACK_x, sda_oe=1. On the next SCL falling edge, sda_oe=0.
  - ACK_A -> BYTE1. ACK_1 -> BYTE2.
  - ACK_2 -> IGNORE. On that same release cycle wr_valid=1 for exactly one clk, with wr_addr=byte1[7:1] and wr_data={byte1[0], byte2}.
- IGNORE: sda_oe=0. Any further bytes are NACKed (SDA released) and do not change outputs. Wait for START or STOP.
- STOP in any state -> IDLE, busy=0, sda_oe=0 within 1 clk.
  - If state was BYTE1, ACK_1 or BYTE2: err_count+1 (aborted write), no wr_valid.
  - STOP during ACK_2 before the release edge: the write is discarded and counted as aborted.
- Repeated START in any state -> ADDR, bit counter=0, sda_oe=0. Same abort/err rule as STOP.
- err_count saturates at 255 and never wraps.
- Latency: sda_oe follows an SCL falling pin edge by 2+FILTER_LEN+1 clk cycles maximum.
- Reset asserted mid-transaction: immediate return to reset values. After release, the block stays in IDLE until a fresh START; the in-flight bytes are lost.

Test Plan:
- Write addr 0x34 (0x1A,W), bytes 0x0C, 0x55 -> three ACK pulses on sda_oe; wr_valid single cycle with wr_addr=0x06, wr_data=0x055; err_count=0; busy falls on STOP.
- Write 0x34, 0x1F, 0xFF -> wr_addr=0x0F, wr_data=0x1FF. Then write 0x34, 0x00, 0x17 back-to-back via repeated START -> second strobe wr_addr=0x00, wr_data=0x017.
- Address 0x36 (0x1B,W) -> no ACK, sda_oe stays 0 for the whole transfer, no wr_valid, err_count=0. Address 0x35 (0x1A,R) -> no ACK, err_count=1.
- STOP after 0x34 and 4 bits of byte1 -> sda_oe=0, busy=0, no wr_valid, err_count+1. A subsequent valid write completes normally.
- 1-cycle and 2-cycle glitches on SCL high and SDA with FILTER_LEN=3 -> no spurious START/STOP or extra bit; 4-byte write -> 4th byte NACKed, exactly one wr_valid.
- Assert reset while sda_oe=1 during ACK_1 -> sda_oe=0 asynchronously, all outputs at reset values. 256 matched reads -> err_count holds at 255.

Source files
------------

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target for the audio codec control port.
// Accepts device address + two data bytes and emits one register-write strobe per transfer.
module i2c_codec_responder #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h1A,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned BCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
    } state_t;

    // index 0 carries SCL, index 1 carries SDA
    logic [1:0]        sync1, sync2, filt, filt_d;
    logic [FCNT_W-1:0] fcnt [2];

    state_t            state;
    logic [BCNT_W-1:0] bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        byte1;

    logic scl_rise, scl_fall, start_det, stop_det, aborting;
    logic [7:0] cur_byte;

    // Synchroniser and glitch filter: a level is accepted after FILTER_LEN identical samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        scl_rise  = filt[0] & ~filt_d[0];
        scl_fall  = ~filt[0] & filt_d[0];
        start_det = ~filt[1] & filt_d[1] & filt[0];
        stop_det  = filt[1] & ~filt_d[1] & filt[0];
        aborting  = (state == BYTE1) || (state == ACK_1) || (state == BYTE2) || (state == ACK_2);
        cur_byte  = {shreg[6:0], filt[1]};
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Protocol FSM; START/STOP override any bit activity in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte1     <= '0;
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (stop_det || start_det) begin
                if (aborting) begin
                    err_count <= sat_inc(err_count);
                end
                state   <= stop_det ? IDLE : ADDR;
                busy    <= ~stop_det;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise && (bit_cnt < BCNT_W'(8))) begin
                            shreg   <= cur_byte;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BCNT_W'(7)) begin
                                if (state == ADDR) begin
                                    if (cur_byte[7:1] != DEVICE_ADDR) begin
                                        state <= IGNORE;
                                    end else if (cur_byte[0]) begin
                                        err_count <= sat_inc(err_count);
                                        state     <= IGNORE;
                                    end
                                end else if (state == BYTE1) begin
                                    byte1 <= cur_byte;
                                end
                            end
                        end else if (scl_fall && (bit_cnt == BCNT_W'(8))) begin
                            // byte accepted: pull SDA low for the acknowledge bit
                            sda_oe  <= 1'b1;
                            bit_cnt <= '0;
                            case (state)
                                ADDR:    state <= ACK_A;
                                BYTE1:   state <= ACK_1;
                                default: state <= ACK_2;
                            endcase
                        end
                    end
                    ACK_A, ACK_1, ACK_2: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            case (state)
                                ACK_A:   state <= BYTE1;
                                ACK_1:   state <= BYTE2;
                                default: begin
                                    state    <= IGNORE;
                                    wr_valid <= 1'b1;
                                    wr_addr  <= byte1[7:1];
                                    wr_data  <= {byte1[0], shreg};
                                end
                            endcase
                        end
                    end
                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
